knn_vote: RTL and testbench
===========================

// Module: knn_vote
// PURPOSE
//  Majority-vote classifier stage of the KNN system, directly downstream of distance_sort.
//  On valid_sort it captures the K nearest class labels (entries 0..K-1 of the ascending-sorted type array).
//  It tallies one label per cycle, then scans the tallies for the winner.
//  It reports the winning class and its vote count with a one-cycle valid_class pulse.
// PARAMETERS
//  N       100  entries in the sorted array delivered by distance_sort
//  K       5    neighbours voting; must satisfy 1 <= K <= N
//  TYPE_W  3    label width; NT = 2**TYPE_W labels (0..NT-1, all legal)
//  localparam CNT_W = $clog2(K+1)   vote counter width
//  localparam IDX_W = $clog2(K)     rank index width (minimum 1)
// PORTS
//  clk                input   1           single clock, rising edge
//  rst                input   1           synchronous, active-high reset
//  valid_sort         input   1           sorted array valid (from distance_sort)
//  type_array_sorted  input   N*TYPE_W    rank i label at [i*TYPE_W +: TYPE_W]; rank 0 = nearest
//  busy               output  1           high whenever state != IDLE
//  class_out          output  TYPE_W      winning label
//  vote_count         output  CNT_W       votes for class_out
//  valid_class        output  1           one-cycle pulse: class_out/vote_count updated
// BEHAVIOUR
//  Reset (rst high at clk edge):
//   - state=IDLE; class_out=0, vote_count=0, valid_class=0, busy=0.
//   - All tallies and the rank counter are cleared.
//   - Reset mid-operation aborts the job with no valid_class pulse; the block accepts a new job from the next cycle.
//  FSM: IDLE -> COUNT -> SELECT -> DONE -> IDLE
//   IDLE:   valid_sort=1 at edge E0:
//           - latch labels rank 0..K-1 into an internal K*TYPE_W register;
//           - clear cnt[0..NT-1] and first[0..NT-1];
//           - go to COUNT.
//           valid_sort in any other state is ignored; there is no queueing.
//   COUNT:  edges E1..EK each process rank r = 0..K-1 with label L:
//           - cnt[L]++;
//           - if cnt[L] was 0, first[L] = r.
//           Go to SELECT after rank K-1.
//   SELECT: edges EK+1..EK+NT scan label t = 0..NT-1.
//           Best starts empty (best_cnt = 0). Replace best with t when:
//           - cnt[t] > best_cnt, or
//           - cnt[t] == best_cnt != 0 and first[t] < best_first.
//           Ties therefore go to the label of the nearest neighbour among the tied labels.
//           A zero-count label is never chosen.
//   DONE:   class_out and vote_count are registered at edge EK+NT+1.
//           valid_class is high for exactly the cycle after that edge. Next edge returns to IDLE.
//  Latency: valid_sort sampled at E0 -> valid_class high after E(K+NT+1); 14 cycles at defaults.
//   Throughput: one job per K+NT+2 cycles.
//  class_out and vote_count hold their values between jobs until the next DONE or reset.
//  Arithmetic: cnt never exceeds K, so CNT_W bits cannot overflow.
//   Labels at ranks >= K are never read. type_array_sorted is sampled only at E0 and may change afterwards.
// TESTING  (defaults N=100, K=5, TYPE_W=3)
//  1 ranks0-4 = 2,2,3,1,2 -> class_out=2, vote_count=3; valid_class high exactly 14 cycles after valid_sort, one cycle only.
//  2 tie: 3,1,1,3,4 -> cnt[3]=cnt[1]=2; class_out=3 (first at rank 0), vote_count=2.
//  3 all distinct 5,4,3,2,1 -> class_out=5, vote_count=1. Label 0 case: 0,0,7,7,7 -> class_out=7, vote_count=3.
//  4 ranks0-4 = 1,1,1,2,2 and ranks5-99 all 2 -> class_out=1, vote_count=3 (ranks >= K ignored).
//  5 valid_sort re-pulsed while busy -> no second valid_class, result unchanged.
//    rst at cycle 3 of COUNT -> no pulse, outputs 0, busy=0 next cycle; a new job then gives the correct result.
//  6 Three back-to-back jobs from distance_sort with random distances (ranges 100/200/1000, labels 1-5):
//    class_out matches a reference model of the mode of the first K sorted labels, with the nearest-rank tie-break.

Source files
------------

// File: rtl/knn_vote.sv
// Majority-vote stage of the KNN classifier: tallies the K nearest labels,
// then scans the tallies and reports the winning class and its vote count.
module knn_vote #(
   parameter  int N      = 100,
   parameter  int K      = 5,
   parameter  int TYPE_W = 3,
   localparam int CNT_W  = $clog2(K + 1),
   localparam int IDX_W  = (K > 1) ? $clog2(K) : 1,
   localparam int NT     = 2 ** TYPE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_sort,
   input  logic [N*TYPE_W-1:0] type_array_sorted,
   output logic                busy,
   output logic [TYPE_W-1:0]   class_out,
   output logic [CNT_W-1:0]    vote_count,
   output logic                valid_class
);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      SELECT,
      DONE
   } state_t;

   state_t              state;
   logic [K*TYPE_W-1:0] labels;
   logic [IDX_W-1:0]    rank;
   logic [TYPE_W-1:0]   scan;
   logic [CNT_W-1:0]    cnt   [NT];
   logic [IDX_W-1:0]    first [NT];
   logic [TYPE_W-1:0]   best_t;
   logic [CNT_W-1:0]    best_cnt;
   logic [IDX_W-1:0]    best_first;

   logic [TYPE_W-1:0]   cur;
   logic [CNT_W-1:0]    cur_cnt;
   logic [CNT_W-1:0]    scan_cnt;
   logic [IDX_W-1:0]    scan_first;
   logic                take;

   // Ranks at K and beyond never vote.
   generate
      if (N > K) begin : g_unused
         wire unused_ranks = ^type_array_sorted[N*TYPE_W-1:K*TYPE_W];
      end
   endgenerate

   assign busy = (state != IDLE);

   // Label under the rank counter and tally under the scan counter.
   always_comb begin
      cur        = labels[rank*TYPE_W +: TYPE_W];
      cur_cnt    = cnt[cur];
      scan_cnt   = cnt[scan];
      scan_first = first[scan];
      take       = 1'b0;
      if (scan_cnt > best_cnt)
         take = 1'b1;
      else if (scan_cnt == best_cnt && best_cnt != '0
               && scan_first < best_first)
         take = 1'b1;
   end

   // Job sequencer: capture, tally one rank per cycle, scan, report.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         class_out   <= '0;
         vote_count  <= '0;
         valid_class <= 1'b0;
         labels      <= '0;
         rank        <= '0;
         scan        <= '0;
         best_t      <= '0;
         best_cnt    <= '0;
         best_first  <= '0;
         for (int i = 0; i < NT; i++) begin
            cnt[i]   <= '0;
            first[i] <= '0;
         end
      end else begin
         valid_class <= 1'b0;
         unique case (state)
            IDLE: begin
               if (valid_sort) begin
                  labels     <= type_array_sorted[K*TYPE_W-1:0];
                  rank       <= '0;
                  scan       <= '0;
                  best_t     <= '0;
                  best_cnt   <= '0;
                  best_first <= '0;
                  for (int i = 0; i < NT; i++) begin
                     cnt[i]   <= '0;
                     first[i] <= '0;
                  end
                  state <= COUNT;
               end
            end
            COUNT: begin
               cnt[cur] <= cur_cnt + CNT_W'(1);
               if (cur_cnt == '0)
                  first[cur] <= rank;
               if (rank == IDX_W'(K - 1))
                  state <= SELECT;
               else
                  rank <= rank + IDX_W'(1);
            end
            SELECT: begin
               if (take) begin
                  best_t     <= scan;
                  best_cnt   <= scan_cnt;
                  best_first <= scan_first;
               end
               if (scan == TYPE_W'(NT - 1))
                  state <= DONE;
               else
                  scan <= scan + TYPE_W'(1);
            end
            DONE: begin
               class_out   <= best_t;
               vote_count  <= best_cnt;
               valid_class <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_knn_vote.sv
// Directed and random bench for knn_vote; a queue of expected results
// is checked against each valid_class pulse.
module tb_knn_vote;
   localparam int N      = 100;
   localparam int K      = 5;
   localparam int TYPE_W = 3;
   localparam int NT     = 8;
   localparam int CNT_W  = 3;
   localparam int LAT    = K + NT + 1;

   typedef struct {
      int cls;
      int votes;
      int start;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                valid_sort = 1'b0;
   logic [N*TYPE_W-1:0] type_array_sorted = '0;
   logic                busy;
   logic [TYPE_W-1:0]   class_out;
   logic [CNT_W-1:0]    vote_count;
   logic                valid_class;

   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;
   int   cyc    = 0;
   logic last_vc = 1'b0;
   exp_t q[$];

   knn_vote #(.N(N), .K(K), .TYPE_W(TYPE_W)) dut (
      .clk(clk),
      .rst(rst),
      .valid_sort(valid_sort),
      .type_array_sorted(type_array_sorted),
      .busy(busy),
      .class_out(class_out),
      .vote_count(vote_count),
      .valid_class(valid_class)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every rising valid_class pops one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (last_vc)
         check("pulse_width", int'(valid_class), 0);
      if (valid_class && !last_vc) begin
         if (q.size() == 0) begin
            check("spurious_pulse", 1, 0);
         end else begin
            e = q.pop_front();
            check("class_out", int'(class_out), e.cls);
            check("vote_count", int'(vote_count), e.votes);
            check("latency", cyc - e.start, LAT);
         end
      end
      last_vc = valid_class;
   end

   function automatic logic [N*TYPE_W-1:0] mk(
      input int a0, input int a1, input int a2,
      input int a3, input int a4, input int rest);
      logic [N*TYPE_W-1:0] v;
      int l[5];
      l = '{a0, a1, a2, a3, a4};
      for (int i = 0; i < N; i++)
         v[i*TYPE_W +: TYPE_W] = TYPE_W'(i < 5 ? l[i] : rest);
      return v;
   endfunction

   // Called at a negedge; drives one valid_sort cycle.
   task automatic send(input logic [N*TYPE_W-1:0] arr, input bit expect_out,
                       input int cls, input int votes);
      exp_t e;
      type_array_sorted = arr;
      valid_sort = 1'b1;
      if (expect_out) begin
         e.cls = cls;
         e.votes = votes;
         e.start = cyc + 1;
         q.push_back(e);
      end
      @(negedge clk);
      valid_sort = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while ((q.size() != 0 || busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("wait_bound", int'(t < 200), 1);
      @(negedge clk);
   endtask

   // Random job: sort by distance (stable), reference mode with
   // earliest-rank tie-break.
   task automatic rand_job(input int range, output logic [N*TYPE_W-1:0] arr,
                           output int cls, output int votes);
      int d[N];
      int l[N];
      int td, tl, c;
      for (int i = 0; i < N; i++) begin
         d[i] = $urandom_range(range - 1, 0);
         l[i] = $urandom_range(5, 1);
      end
      for (int i = 1; i < N; i++)
         for (int j = i; j > 0 && d[j-1] > d[j]; j--) begin
            td = d[j]; d[j] = d[j-1]; d[j-1] = td;
            tl = l[j]; l[j] = l[j-1]; l[j-1] = tl;
         end
      for (int i = 0; i < N; i++)
         arr[i*TYPE_W +: TYPE_W] = TYPE_W'(l[i]);
      cls = 0;
      votes = 0;
      for (int r = 0; r < K; r++) begin
         c = 0;
         for (int j = 0; j < K; j++)
            if (l[j] == l[r]) c++;
         if (c > votes) begin
            votes = c;
            cls = l[r];
         end
      end
   endtask

   initial begin
      logic [N*TYPE_W-1:0] ra[3];
      int rc[3];
      int rv[3];

      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_class", int'(class_out), 0);
      check("rst_votes", int'(vote_count), 0);
      check("rst_valid", int'(valid_class), 0);
      check("rst_busy", int'(busy), 0);

      send(mk(2, 2, 3, 1, 2, 0), 1'b1, 2, 3);
      check("busy_run", int'(busy), 1);
      wait_done();
      send(mk(3, 1, 1, 3, 4, 0), 1'b1, 3, 2);
      wait_done();
      send(mk(5, 4, 3, 2, 1, 0), 1'b1, 5, 1);
      wait_done();
      send(mk(0, 0, 7, 7, 7, 0), 1'b1, 7, 3);
      wait_done();
      send(mk(1, 1, 1, 2, 2, 2), 1'b1, 1, 3);
      wait_done();
      check("hold_class", int'(class_out), 1);
      check("hold_votes", int'(vote_count), 3);

      send(mk(6, 6, 0, 0, 6, 0), 1'b1, 6, 3);
      repeat (3) @(negedge clk);
      send(mk(7, 7, 7, 7, 7, 7), 1'b0, 0, 0);
      repeat (2) @(negedge clk);
      send(mk(4, 4, 4, 4, 4, 4), 1'b0, 0, 0);
      wait_done();
      repeat (16) @(negedge clk);
      check("ignore_class", int'(class_out), 6);
      check("ignore_votes", int'(vote_count), 3);

      send(mk(3, 3, 3, 5, 5, 0), 1'b0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_class", int'(class_out), 0);
      check("abort_votes", int'(vote_count), 0);
      check("abort_valid", int'(valid_class), 0);
      repeat (20) @(negedge clk);
      send(mk(4, 2, 2, 4, 6, 1), 1'b1, 4, 2);
      wait_done();

      rand_job(100, ra[0], rc[0], rv[0]);
      rand_job(200, ra[1], rc[1], rv[1]);
      rand_job(1000, ra[2], rc[2], rv[2]);
      for (int j = 0; j < 3; j++) begin
         send(ra[j], 1'b1, rc[j], rv[j]);
         if (j < 2) repeat (LAT) @(negedge clk);
      end
      wait_done();
      check("queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
